control_unit_fsm: RTL and testbench

//   Multi-cycle control unit sitting directly upstream of the datapath (register file, adder,

---
 rtl/control_unit_fsm_if.sv | 75 +++++++
 rtl/control_unit_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_fsm_if.sv
// ---------------------------------------------------------------------------
// control_unit_fsm_if
//   Bundles the instruction handshake and the datapath control lines that
//   run between the instruction source, the control unit and the datapath.
//
//   Parameters
//     XLEN        datapath width; width of the sign-extended immediate C
//     REG_ADDR_W  register index width
//
//   Signals
//     instr_valid  source -> unit   instr holds a valid instruction
//     instr_ready  unit -> source   unit can accept (only while idle)
//     instr        source -> unit   32-bit RV64I instruction word
//     Ra, Rb, Rw   unit -> datapath rs1 / rs2 / rd register indices
//     C            unit -> datapath sign-extended immediate
//     sinal        unit -> datapath adder op: 0 add, 1 sub
//     sinalMux     unit -> datapath 0: S1=C, S2=mem dout; 1: S1=doutB, S2=soma
//     weReg        unit -> datapath register-file write enable pulse
//     weMem        unit -> datapath memory write enable pulse
//     busy         unit -> source   instruction in flight
//     done         unit -> source   pulse in the last state of an instruction
//     err          unit -> source   sticky illegal-instruction flag; present
//                                   only when CTRL_ILLEGAL_TRAP_EN is defined
//
//   Modports
//     master : instruction source / datapath side
//     slave  : control unit side
// ---------------------------------------------------------------------------
interface control_unit_fsm_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
);

  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [REG_ADDR_W-1:0] Ra;
  logic [REG_ADDR_W-1:0] Rb;
  logic [REG_ADDR_W-1:0] Rw;
  logic [XLEN-1:0]       C;
  logic                  sinal;
  logic                  sinalMux;
  logic                  weReg;
  logic                  weMem;
  logic                  busy;
  logic                  done;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                  err;

  modport master (
    output instr_valid, instr,
    input  instr_ready, Ra, Rb, Rw, C, sinal, sinalMux, weReg, weMem,
           busy, done, err
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, Ra, Rb, Rw, C, sinal, sinalMux, weReg, weMem,
           busy, done, err
  );
`else
  modport master (
    output instr_valid, instr,
    input  instr_ready, Ra, Rb, Rw, C, sinal, sinalMux, weReg, weMem,
           busy, done
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, Ra, Rb, Rw, C, sinal, sinalMux, weReg, weMem,
           busy, done
  );
`endif

endinterface

// File: rtl/control_unit_fsm.sv
// ---------------------------------------------------------------------------
// control_unit_fsm
//   Multi-cycle control unit in front of the datapath (register file, adder,
//   memory, Mux1/Mux2). Takes one 32-bit RV64I instruction at a time over a
//   valid/ready handshake, decodes ld/sd/add/sub and sequences the register
//   indices, immediate, adder op, mux select and the two write enables.
//
//   Sequences (cycles counted from the accepting clock edge):
//     ld      DECODE, EXEC, MEM, WB   weReg in WB  (4 cycles)
//     sd      DECODE, EXEC, MEM       weMem in MEM (3 cycles)
//     add/sub DECODE, EXEC, WB        weReg in WB  (3 cycles)
//   done pulses in the last state; a new instruction can be accepted the
//   cycle after done. rd == x0 runs the full sequence without weReg.
//
//   Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//     defined     : unrecognised encoding goes DECODE -> ERR and stays there
//                   with err=1, busy=1, instr_ready=0 until reset.
//     not defined : unrecognised encoding runs as a NOP (DECODE, EXEC, done)
//                   and the err signal does not exist.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    control_unit_fsm_if.slave (handshake + datapath controls)
//
//   Every output is driven straight from a flop; nothing in instr reaches
//   an output without passing through a register.
// ---------------------------------------------------------------------------
module control_unit_fsm #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  control_unit_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ERR
  } state_e;

  typedef enum logic [2:0] {
    OP_LD,
    OP_SD,
    OP_ADD,
    OP_SUB,
    OP_ILL
  } op_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [2:0] F3_DWORD  = 3'b011;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] c_q, c_d;
  logic            sinal_q, sinal_d;
  logic            sinal_mux_q, sinal_mux_d;
  logic            we_reg_q, we_reg_d;
  logic            we_mem_q, we_mem_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic            err_q, err_d;
`endif

  // Opcode and funct7 bits only matter at decode time; the IR keeps them so
  // the register reads as the whole instruction word.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir_q[31:25], ir_q[14:12], ir_q[6:0]};

  // -------------------------------------------------------------------------
  // Instruction decode of the incoming word (used only on the accept edge)
  // -------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  op_e             op_dec;
  logic [XLEN-1:0] imm_dec;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];

  always_comb begin
    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path through the block leaves it unassigned and no latch appears.
    op_dec  = OP_ILL;
    imm_dec = '0;
    if (opcode == OPC_LOAD && funct3 == F3_DWORD) begin
      op_dec  = OP_LD;
      imm_dec = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    end else if (opcode == OPC_STORE && funct3 == F3_DWORD) begin
      op_dec  = OP_SD;
      imm_dec = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    end else if (opcode == OPC_OP && funct3 == F3_ADDSUB && funct7 == F7_ADD) begin
      op_dec  = OP_ADD;
    end else if (opcode == OPC_OP && funct3 == F3_ADDSUB && funct7 == F7_SUB) begin
      op_dec  = OP_SUB;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and next values of the registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ir_d        = ir_q;
    c_d         = c_q;
    sinal_d     = sinal_q;
    sinal_mux_d = sinal_mux_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          state_d     = S_DECODE;
          op_d        = op_dec;
          ir_d        = bus.instr;
          c_d         = imm_dec;
          sinal_d     = (op_dec == OP_SUB);
          sinal_mux_d = (op_dec == OP_ADD) || (op_dec == OP_SUB);
        end
      end
      S_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        state_d = (op_q == OP_ILL) ? S_ERR : S_EXEC;
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        unique case (op_q)
          OP_LD, OP_SD:   state_d = S_MEM;
          OP_ADD, OP_SUB: state_d = S_WB;
          default:        state_d = S_IDLE;  // NOP: EXEC is the last state
        endcase
      end
      S_MEM:   state_d = (op_q == OP_LD) ? S_WB : S_IDLE;
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;              // left only through reset
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered so that the flops
    // present them during that state without a combinational tail.
    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d != S_IDLE);
    we_reg_d = (state_d == S_WB) && (ir_d[11:7] != 5'd0);
    we_mem_d = (state_d == S_MEM) && (op_d == OP_SD);
    done_d   = (state_d == S_WB)
            || ((state_d == S_MEM)  && (op_d == OP_SD))
            || ((state_d == S_EXEC) && (op_d == OP_ILL));
`ifdef CTRL_ILLEGAL_TRAP_EN
    err_d    = (state_d == S_ERR);
`endif
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ILL;
      ir_q        <= '0;
      c_q         <= '0;
      sinal_q     <= 1'b0;
      sinal_mux_q <= 1'b0;
      we_reg_q    <= 1'b0;
      we_mem_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ir_q        <= ir_d;
      c_q         <= c_d;
      sinal_q     <= sinal_d;
      sinal_mux_q <= sinal_mux_d;
      we_reg_q    <= we_reg_d;
      we_mem_q    <= we_mem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      err_q       <= err_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign bus.instr_ready = ready_q;
  assign bus.Ra          = REG_ADDR_W'(ir_q[19:15]);
  assign bus.Rb          = REG_ADDR_W'(ir_q[24:20]);
  assign bus.Rw          = REG_ADDR_W'(ir_q[11:7]);
  assign bus.C           = c_q;
  assign bus.sinal       = sinal_q;
  assign bus.sinalMux    = sinal_mux_q;
  assign bus.weReg       = we_reg_q;
  assign bus.weMem       = we_mem_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.err         = err_q;
`endif

endmodule

// File: tb/tb_control_unit_fsm.sv
// ---------------------------------------------------------------------------
// tb_control_unit_fsm
//   Directed bench for control_unit_fsm. Each scenario task issues hand-
//   encoded instructions and compares the observed control sequence against
//   hand-computed values. Cycle k=1 is the cycle right after the accepting
//   edge (DECODE). Works with and without CTRL_ILLEGAL_TRAP_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_unit_fsm;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  control_unit_fsm_if #(.XLEN(64), .REG_ADDR_W(5)) ifc ();

  control_unit_fsm #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one instruction and record what the unit does until done (or a
  // 12-cycle limit). Register fields are captured in DECODE; stable clears
  // if any of them moves before done.
  task automatic issue(input logic [31:0] w,
                       output int wait_cyc, output int done_cyc,
                       output int wr_cyc, output int wr_cnt,
                       output int wm_cyc, output int wm_cnt,
                       output logic [4:0] ra, output logic [4:0] rb,
                       output logic [4:0] rw, output logic [63:0] c,
                       output logic s, output logic sm,
                       output logic stable, output logic busy1,
                       output logic ready1);
    wait_cyc = 0; done_cyc = -1; wr_cyc = -1; wr_cnt = 0;
    wm_cyc = -1; wm_cnt = 0; stable = 1'b1;
    @(negedge clk);
    while (ifc.instr_ready !== 1'b1 && wait_cyc < 20) begin
      wait_cyc++;
      @(negedge clk);
    end
    ifc.instr       = w;
    ifc.instr_valid = 1'b1;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    ra = ifc.Ra; rb = ifc.Rb; rw = ifc.Rw; c = ifc.C;
    s = ifc.sinal; sm = ifc.sinalMux;
    busy1 = ifc.busy; ready1 = ifc.instr_ready;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (ifc.weReg === 1'b1) begin wr_cnt++; wr_cyc = k; end
      if (ifc.weMem === 1'b1) begin wm_cnt++; wm_cyc = k; end
      if ({ifc.Ra, ifc.Rb, ifc.Rw, ifc.C, ifc.sinal, ifc.sinalMux} !==
          {ra, rb, rw, c, s, sm}) stable = 1'b0;
      if (ifc.done === 1'b1) begin
        done_cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.instr_valid = 1'b0;
    ifc.instr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifc.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", ifc.instr_ready); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", ifc.busy); end
    checks++; if ({ifc.done, ifc.weReg, ifc.weMem, ifc.sinal, ifc.sinalMux} !== 5'b0) begin errors++; $display("FAIL reset_pulses got %05b exp 00000", {ifc.done, ifc.weReg, ifc.weMem, ifc.sinal, ifc.sinalMux}); end
    checks++; if ({ifc.Ra, ifc.Rb, ifc.Rw} !== 15'd0 || ifc.C !== 64'd0) begin errors++; $display("FAIL reset_fields got Ra=%0d Rb=%0d Rw=%0d C=%0h exp all 0", ifc.Ra, ifc.Rb, ifc.Rw, ifc.C); end
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++; if (ifc.err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", ifc.err); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ld();
    int wt, dc, wrc, wrn, wmc, wmn;
    logic [4:0] ra, rb, rw; logic [63:0] c; logic s, sm, st, b1, r1;
    issue(32'h00003083, wt, dc, wrc, wrn, wmc, wmn, ra, rb, rw, c, s, sm, st, b1, r1);
    checks++; if (dc !== 4) begin errors++; $display("FAIL ld_done_cycle got %0d exp 4", dc); end
    checks++; if (wrc !== 4 || wrn !== 1) begin errors++; $display("FAIL ld_wereg got cycle %0d count %0d exp cycle 4 count 1", wrc, wrn); end
    checks++; if (wmn !== 0) begin errors++; $display("FAIL ld_wemem got count %0d exp 0", wmn); end
    checks++; if (ra !== 5'd0 || rw !== 5'd1 || c !== 64'd0) begin errors++; $display("FAIL ld_fields got Ra=%0d Rw=%0d C=%0h exp 0 1 0", ra, rw, c); end
    checks++; if (sm !== 1'b0 || s !== 1'b0) begin errors++; $display("FAIL ld_ctrl got sinalMux=%0b sinal=%0b exp 0 0", sm, s); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL ld_stable got %0b exp 1", st); end
    checks++; if (b1 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL ld_busy_ready got busy=%0b ready=%0b exp 1 0", b1, r1); end
    @(posedge clk); #1;
    checks++; if (ifc.instr_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin errors++; $display("FAIL ld_idle got ready=%0b busy=%0b done=%0b exp 1 0 0", ifc.instr_ready, ifc.busy, ifc.done); end
    checks++; if (ifc.Rw !== 5'd1) begin errors++; $display("FAIL ld_held_idle got Rw=%0d exp 1", ifc.Rw); end
  endtask

  task automatic test_back_to_back();
    int wt, dc, wrc, wrn, wmc, wmn;
    logic [4:0] ra, rb, rw; logic [63:0] c; logic s, sm, st, b1, r1;
    issue(32'h00803103, wt, dc, wrc, wrn, wmc, wmn, ra, rb, rw, c, s, sm, st, b1, r1);
    checks++; if (dc !== 4 || rw !== 5'd2 || c !== 64'd8) begin errors++; $display("FAIL b2b_ld got done=%0d Rw=%0d C=%0h exp 4 2 8", dc, rw, c); end
    issue(32'h001101B3, wt, dc, wrc, wrn, wmc, wmn, ra, rb, rw, c, s, sm, st, b1, r1);
    checks++; if (wt !== 1) begin errors++; $display("FAIL b2b_ready_gap got %0d exp 1", wt); end
    checks++; if (dc !== 3 || wrc !== 3 || wrn !== 1) begin errors++; $display("FAIL add_timing got done=%0d weReg_cyc=%0d cnt=%0d exp 3 3 1", dc, wrc, wrn); end
    checks++; if (ra !== 5'd2 || rb !== 5'd1 || rw !== 5'd3) begin errors++; $display("FAIL add_regs got Ra=%0d Rb=%0d Rw=%0d exp 2 1 3", ra, rb, rw); end
    checks++; if (sm !== 1'b1 || s !== 1'b0 || c !== 64'd0) begin errors++; $display("FAIL add_ctrl got sinalMux=%0b sinal=%0b C=%0h exp 1 0 0", sm, s, c); end
  endtask

  task automatic test_sub();
    int wt, dc, wrc, wrn, wmc, wmn;
    logic [4:0] ra, rb, rw; logic [63:0] c; logic s, sm, st, b1, r1;
    issue(32'h40118233, wt, dc, wrc, wrn, wmc, wmn, ra, rb, rw, c, s, sm, st, b1, r1);
    checks++; if (s !== 1'b1 || sm !== 1'b1) begin errors++; $display("FAIL sub_ctrl got sinal=%0b sinalMux=%0b exp 1 1", s, sm); end
    checks++; if (ra !== 5'd3 || rb !== 5'd1 || rw !== 5'd4) begin errors++; $display("FAIL sub_regs got Ra=%0d Rb=%0d Rw=%0d exp 3 1 4", ra, rb, rw); end
    checks++; if (dc !== 3 || wrn !== 1 || wmn !== 0) begin errors++; $display("FAIL sub_pulses got done=%0d weReg=%0d weMem=%0d exp 3 1 0", dc, wrn, wmn); end
  endtask

  task automatic test_sd();
    int wt, dc, wrc, wrn, wmc, wmn;
    logic [4:0] ra, rb, rw; logic [63:0] c; logic s, sm, st, b1, r1;
    issue(32'hFE62BC23, wt, dc, wrc, wrn, wmc, wmn, ra, rb, rw, c, s, sm, st, b1, r1);
    checks++; if (ra !== 5'd5 || rb !== 5'd6) begin errors++; $display("FAIL sd_regs got Ra=%0d Rb=%0d exp 5 6", ra, rb); end
    checks++; if (c !== 64'hFFFFFFFFFFFFFFF8) begin errors++; $display("FAIL sd_imm got %0h exp fffffffffffffff8", c); end
    checks++; if (dc !== 3 || wmc !== 3 || wmn !== 1) begin errors++; $display("FAIL sd_wemem got done=%0d cyc=%0d cnt=%0d exp 3 3 1", dc, wmc, wmn); end
    checks++; if (wrn !== 0 || sm !== 1'b0) begin errors++; $display("FAIL sd_misc got weReg=%0d sinalMux=%0b exp 0 0", wrn, sm); end
  endtask

  task automatic test_rd_zero();
    int wt, dc, wrc, wrn, wmc, wmn;
    logic [4:0] ra, rb, rw; logic [63:0] c; logic s, sm, st, b1, r1;
    issue(32'h00108033, wt, dc, wrc, wrn, wmc, wmn, ra, rb, rw, c, s, sm, st, b1, r1);
    checks++; if (dc !== 3) begin errors++; $display("FAIL x0_done got %0d exp 3", dc); end
    checks++; if (wrn !== 0 || wmn !== 0) begin errors++; $display("FAIL x0_enables got weReg=%0d weMem=%0d exp 0 0", wrn, wmn); end
  endtask

  task automatic test_illegal();
    int wt, dc, wrc, wrn, wmc, wmn;
    logic [4:0] ra, rb, rw; logic [63:0] c; logic s, sm, st, b1, r1;
    issue(32'h00000000, wt, dc, wrc, wrn, wmc, wmn, ra, rb, rw, c, s, sm, st, b1, r1);
    checks++; if (wrn !== 0 || wmn !== 0) begin errors++; $display("FAIL ill_enables got weReg=%0d weMem=%0d exp 0 0", wrn, wmn); end
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++; if (dc !== -1) begin errors++; $display("FAIL ill_done got %0d exp none", dc); end
    checks++; if (ifc.err !== 1'b1 || ifc.busy !== 1'b1 || ifc.instr_ready !== 1'b0) begin errors++; $display("FAIL ill_trap got err=%0b busy=%0b ready=%0b exp 1 1 0", ifc.err, ifc.busy, ifc.instr_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.err !== 1'b0 || ifc.instr_ready !== 1'b1) begin errors++; $display("FAIL ill_clear got err=%0b ready=%0b exp 0 1", ifc.err, ifc.instr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
`else
    checks++; if (dc !== 2) begin errors++; $display("FAIL nop_done got %0d exp 2", dc); end
`endif
  endtask

  task automatic test_reset_mid();
    int wt, dc, wrc, wrn, wmc, wmn, late_we;
    logic [4:0] ra, rb, rw; logic [63:0] c; logic s, sm, st, b1, r1;
    @(negedge clk);
    ifc.instr = 32'h00003083;
    ifc.instr_valid = 1'b1;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.instr_ready !== 1'b1 || ifc.busy !== 1'b0) begin errors++; $display("FAIL rstmid_state got ready=%0b busy=%0b exp 1 0", ifc.instr_ready, ifc.busy); end
    checks++; if ({ifc.weReg, ifc.weMem, ifc.done} !== 3'b0 || ifc.Rw !== 5'd0) begin errors++; $display("FAIL rstmid_outputs got we/we/done=%03b Rw=%0d exp 000 0", {ifc.weReg, ifc.weMem, ifc.done}, ifc.Rw); end
    @(negedge clk);
    rst_n = 1'b1;
    late_we = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ifc.weReg === 1'b1 || ifc.done === 1'b1) late_we++;
    end
    checks++; if (late_we !== 0) begin errors++; $display("FAIL rstmid_no_pulse got %0d exp 0", late_we); end
    issue(32'h00003083, wt, dc, wrc, wrn, wmc, wmn, ra, rb, rw, c, s, sm, st, b1, r1);
    checks++; if (dc !== 4 || wrc !== 4 || wrn !== 1) begin errors++; $display("FAIL rstmid_next_ld got done=%0d weReg_cyc=%0d cnt=%0d exp 4 4 1", dc, wrc, wrn); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ld();
    test_back_to_back();
    test_sub();
    test_sd();
    test_rd_zero();
    test_illegal();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
